rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single write port of the 32-entry register bank between two writeback requesters: req 0 = ALU result, req 1 = memory load.
- Round-robin arbitration with a valid/ready handshake per requester; drives the bank's enable/address/data from registers.
- Keeps a pending-write scoreboard so decode logic can stall on read-after-write hazards against the bank's two read ports.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width; the bank holds 2**ADDR_W entries

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
hold  in  1  1 = no new grants this cycle (bank busy / pipeline freeze)
req0_valid  in  1  ALU write request
req0_ready  out  1  ALU request accepted this cycle
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU write data
req1_valid  in  1  load write request
req1_ready  out  1  load request accepted this cycle
req1_addr  in  ADDR_W  load destination register
req1_data  in  DATA_W  load write data
wr_en  out  1  write enable to bank (RegEn)
wr_addr  out  ADDR_W  bank write address (WriteRegister)
wr_data  out  DATA_W  bank write data (WriteData)
rd_addr1  in  ADDR_W  decode read address 1 (ReadRegister1)
rd_addr2  in  ADDR_W  decode read address 2 (ReadRegister2)
stall1  out  1  rd_addr1 has a pending write
stall2  out  1  rd_addr2 has a pending write
busy_vec  out  2**ADDR_W  scoreboard, bit i = write to reg i pending

Behaviour:
- Reset (async, rst_n=0): wr_en=0, wr_addr=0, wr_data=0, busy_vec=0, rr pointer=0 (req0 favoured). req*_ready=0 while reset is asserted.
- Grant (combinational): hold=1 -> no grant. Only one valid -> that one. Both valid -> requester indicated by rr pointer. req*_ready = grant; handshake = valid & ready.
- rr pointer: after each accepted handshake, points to the requester that was not granted. Unchanged on idle cycles or while hold=1.
- Output stage: registered, latency 1. Handshake in cycle N -> wr_en=1, wr_addr/wr_data = granted request in cycle N+1. No handshake -> wr_en=0 next cycle; wr_addr/wr_data hold their last values.
- Register 0: a request to addr 0 is accepted (ready=1) but wr_en stays 0 and busy bit 0 is never set.
- Scoreboard: busy[a] is set on the cycle the handshake for addr a completes, so it is 1 in cycle N+1 alongside wr_en. It is cleared the cycle after wr_en for a, when the bank has absorbed the write. Set and clear of the same bit in the same cycle -> set wins.
- stall1 = busy_vec[rd_addr1], stall2 = busy_vec[rd_addr2]; both combinational and 0 for address 0.
- Back-to-back requests to the same address: serialized in grant order; the later write lands last.
- hold=1 mid-stream: an already registered write still issues; no new grant until hold=0.
- Reset asserted mid-operation: pending writes are dropped and the scoreboard is cleared.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- Defined: adds outputs byp1_valid, byp1_data, byp2_valid, byp2_data. When wr_en=1 and wr_addr==rd_addrX (X≠0), bypX_valid=1, bypX_data=wr_data, and stallX is forced to 0 for that cycle.
- Undefined: these ports are absent and stall follows the scoreboard only.

Test Plan:
- Reset, then req0 valid addr=5 data=0xDEADBEEF -> ready0=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, busy_vec[5]=1; cleared one cycle later.
- Both valid every cycle, req0 addr=1, req1 addr=2 -> grants alternate 0,1,0,1; wr_addr sequence 1,2,1,2 with no idle cycle.
- req1 addr=0 data=0x1234 -> ready1=1, wr_en stays 0, busy_vec stays 0.
- rd_addr1=7 while a write to 7 is pending -> stall1=1 until busy clears, then 0; rd_addr2=0 -> stall2=0 always.
- hold=1 with both requesters valid for 3 cycles -> both ready=0 and the rr pointer is unchanged; grants resume per the pointer after hold drops.
- Assert rst_n=0 the cycle after a handshake -> wr_en=0 and busy_vec=0 immediately (asynchronous); no write issues after release.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter for the register bank write port, with a pending-write scoreboard.
// Optional macro RF_WRITE_BYPASS_EN adds write-to-read bypass outputs.
module rf_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     hold,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [ADDR_W-1:0]        req0_addr,
   input  logic [DATA_W-1:0]        req0_data,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [ADDR_W-1:0]        req1_addr,
   input  logic [DATA_W-1:0]        req1_data,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   input  logic [ADDR_W-1:0]        rd_addr1,
   input  logic [ADDR_W-1:0]        rd_addr2,
   output logic                     stall1,
   output logic                     stall2,
   output logic [(1<<ADDR_W)-1:0]   busy_vec
`ifdef RF_WRITE_BYPASS_EN
   ,
   output logic                     byp1_valid,
   output logic [DATA_W-1:0]        byp1_data,
   output logic                     byp2_valid,
   output logic [DATA_W-1:0]        byp2_data
`endif
);
   localparam int NB = 1 << ADDR_W;

   logic              rr;
   logic              hs;
   logic              new_wr;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;
   logic [NB-1:0]     set_vec;
   logic [NB-1:0]     clr_vec;

   // rr=0 favours req0 on contention, rr=1 favours req1
   assign req0_ready = rst_n & ~hold & req0_valid & (~req1_valid | ~rr);
   assign req1_ready = rst_n & ~hold & req1_valid & (~req0_valid | rr);
   assign hs         = req0_ready | req1_ready;
   assign g_addr     = req1_ready ? req1_addr : req0_addr;
   assign g_data     = req1_ready ? req1_data : req0_data;
   // writes to register 0 are accepted but discarded
   assign new_wr     = hs && g_addr != '0;
   assign set_vec    = new_wr ? (NB'(1) << g_addr) : '0;
   assign clr_vec    = wr_en ? (NB'(1) << wr_addr) : '0;

`ifdef RF_WRITE_BYPASS_EN
   assign byp1_valid = wr_en && wr_addr == rd_addr1 && rd_addr1 != '0;
   assign byp2_valid = wr_en && wr_addr == rd_addr2 && rd_addr2 != '0;
   assign byp1_data  = wr_data;
   assign byp2_data  = wr_data;
   assign stall1     = busy_vec[rd_addr1] && rd_addr1 != '0 && !byp1_valid;
   assign stall2     = busy_vec[rd_addr2] && rd_addr2 != '0 && !byp2_valid;
`else
   assign stall1     = busy_vec[rd_addr1] && rd_addr1 != '0;
   assign stall2     = busy_vec[rd_addr2] && rd_addr2 != '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr       <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy_vec <= '0;
      end else begin
         if (hs) rr <= req0_ready;
         wr_en <= new_wr;
         if (new_wr) begin
            wr_addr <= g_addr;
            wr_data <= g_data;
         end
         // set wins over a same-cycle clear of the same bit
         busy_vec <= (busy_vec & ~clr_vec) | set_vec;
      end
   end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: table-driven directed vectors plus hand sequences for reset behaviour.
module tb_rf_write_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hold = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [4:0]  req0_addr = '0, req1_addr = '0;
   logic [31:0] req0_data = '0, req1_data = '0;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr1 = '0, rd_addr2 = '0;
   logic        stall1, stall2;
   logic [31:0] busy_vec;
   int          passed = 0;
   int          total = 0;

   rf_write_arbiter dut (
      .clk(clk), .rst_n(rst_n), .hold(hold),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .stall1(stall1), .stall2(stall2), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hold;
      logic        v0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [4:0]  rd1;
      logic [4:0]  rd2;
      logic        r0;
      logic        r1;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] busy;
      logic        s1;
      logic        s2;
   } vec_t;

   vec_t tv[16];

   task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
   endtask

   task automatic check_all(input int row, input vec_t v);
      check("ready0", row, 32'(req0_ready), 32'(v.r0));
      check("ready1", row, 32'(req1_ready), 32'(v.r1));
      check("wr_en", row, 32'(wr_en), 32'(v.we));
      check("wr_addr", row, 32'(wr_addr), 32'(v.wa));
      check("wr_data", row, wr_data, v.wd);
      check("busy_vec", row, busy_vec, v.busy);
      check("stall1", row, 32'(stall1), 32'(v.s1));
      check("stall2", row, 32'(stall2), 32'(v.s2));
   endtask

   initial begin
      //          hold v0 a0  d0           v1 a1  d1      rd1 rd2 | r0 r1 we wa  wd           busy        s1 s2
      tv[0]  = '{0, 1, 1, 32'h11,       1, 2, 32'h22,  1, 2,   1, 0, 0, 0, 32'h0,       32'h0,      0, 0};
      tv[1]  = '{0, 1, 1, 32'h11,       1, 2, 32'h22,  1, 2,   0, 1, 1, 1, 32'h11,      32'h2,      1, 0};
      tv[2]  = '{0, 1, 1, 32'h11,       1, 2, 32'h22,  1, 2,   1, 0, 1, 2, 32'h22,      32'h4,      0, 1};
      tv[3]  = '{0, 1, 1, 32'h11,       1, 2, 32'h22,  1, 2,   0, 1, 1, 1, 32'h11,      32'h2,      1, 0};
      tv[4]  = '{1, 1, 1, 32'h11,       1, 2, 32'h22,  1, 2,   0, 0, 1, 2, 32'h22,      32'h4,      0, 1};
      tv[5]  = '{1, 1, 1, 32'h11,       1, 2, 32'h22,  1, 2,   0, 0, 0, 2, 32'h22,      32'h0,      0, 0};
      tv[6]  = '{1, 1, 1, 32'h11,       1, 2, 32'h22,  1, 2,   0, 0, 0, 2, 32'h22,      32'h0,      0, 0};
      tv[7]  = '{0, 1, 1, 32'h11,       1, 2, 32'h22,  1, 2,   1, 0, 0, 2, 32'h22,      32'h0,      0, 0};
      tv[8]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,   5, 0,   1, 0, 1, 1, 32'h11,      32'h2,      0, 0};
      tv[9]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   5, 0,   0, 0, 1, 5, 32'hDEADBEEF, 32'h20,    1, 0};
      tv[10] = '{0, 0, 0, 32'h0,        1, 0, 32'h1234, 5, 0,  0, 1, 0, 5, 32'hDEADBEEF, 32'h0,     0, 0};
      tv[11] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   7, 0,   0, 0, 0, 5, 32'hDEADBEEF, 32'h0,     0, 0};
      tv[12] = '{0, 1, 7, 32'hA,        1, 7, 32'hB,   7, 0,   1, 0, 0, 5, 32'hDEADBEEF, 32'h0,     0, 0};
      tv[13] = '{0, 1, 7, 32'hA,        1, 7, 32'hB,   7, 0,   0, 1, 1, 7, 32'hA,       32'h80,     1, 0};
      tv[14] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   7, 0,   0, 0, 1, 7, 32'hB,       32'h80,     1, 0};
      tv[15] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   7, 0,   0, 0, 0, 7, 32'hB,       32'h0,      0, 0};

      // ready must stay low while reset is held, even with a valid request
      req0_valid = 1'b1;
      #1;
      check("rst_ready0", -1, 32'(req0_ready), 32'h0);
      check("rst_wr_en", -1, 32'(wr_en), 32'h0);
      check("rst_busy", -1, busy_vec, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         hold = tv[i].hold;
         req0_valid = tv[i].v0; req0_addr = tv[i].a0; req0_data = tv[i].d0;
         req1_valid = tv[i].v1; req1_addr = tv[i].a1; req1_data = tv[i].d1;
         rd_addr1 = tv[i].rd1; rd_addr2 = tv[i].rd2;
         #1;
         check_all(i, tv[i]);
         @(negedge clk);
      end

      // asynchronous reset the cycle after a handshake drops the pending write
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99; rd_addr1 = 5'd9;
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      check("pre_rst_wr_en", 100, 32'(wr_en), 32'h1);
      check("pre_rst_busy", 100, busy_vec, 32'h200);
      rst_n = 1'b0;
      #1;
      check("async_wr_en", 101, 32'(wr_en), 32'h0);
      check("async_busy", 101, busy_vec, 32'h0);
      check("async_wr_addr", 101, 32'(wr_addr), 32'h0);
      check("async_stall1", 101, 32'(stall1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         check("post_rst_wr_en", 102 + i, 32'(wr_en), 32'h0);
         check("post_rst_busy", 102 + i, busy_vec, 32'h0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
